banco_reg_p: RTL

Parametrised, clocked successor to the datapath register bank (`BancoReg`). It has two read ports and one write port, with configurable data width, depth and an optional hardwired zero register. After every reset a scrub state machine clears all entries before the bank accepts traffic. Read data is registered, and same-cycle write-to-read forwarding is a compile-time option. The block sits between instruction decode (RA1/RA2/AW) and the writeback mux (Di/RegWrite) of the single-cycle/pipelined core.

---
 rtl/banco_reg_p.sv | 109 ++++++++++
 1 files changed

// File: rtl/banco_reg_p.sv
// Two-read / one-write register bank that scrubs itself to zero after every reset.
// Optional macro BANCO_REG_P_BYPASS_EN selects write-first forwarding; without it, reads return the old value.
module banco_reg_p #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AWIDTH   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [AWIDTH-1:0] RA1,
    input  logic [AWIDTH-1:0] RA2,
    input  logic [AWIDTH-1:0] AW,
    input  logic [WIDTH-1:0]  Di,
    input  logic              RegWrite,
    output logic [WIDTH-1:0]  DR1,
    output logic [WIDTH-1:0]  DR2,
    output logic              Ready
);

    // state | meaning
    // CLEAR | scrubbing mem[ptr] each edge, traffic ignored, DRn held at 0
    // RUN   | normal reads and writes
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [AWIDTH-1:0]  ptr;
    logic               ptr_last;
    logic               scrub_we;
    logic               run_we;
    logic               wr_legal;
    logic               hit1;
    logic               hit2;
    logic               mask1;
    logic               mask2;
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic [WIDTH-1:0]   mem [DEPTH];

    function automatic logic in_range(input logic [AWIDTH-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    assign ptr_last = (ptr == AWIDTH'(DEPTH - 1));
    assign wr_legal = RegWrite && in_range(AW) && !((ZERO_REG != 0) && (AW == '0));

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (ptr_last) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        Ready    = (state == RUN);
        scrub_we = (state == CLEAR);
        run_we   = (state == RUN) && wr_legal;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn)         ptr <= '0;
        else if (scrub_we) ptr <= ptr_last ? '0 : ptr + 1'b1;
    end

    // Storage is deliberately left untouched on the reset edge; the scrub clears it.
    always_ff @(posedge CLK) begin
        if (RSTn) begin
            if (scrub_we)    mem[ptr[IW-1:0]] <= '0;
            else if (run_we) mem[AW[IW-1:0]]  <= Di;
        end
    end

`ifdef BANCO_REG_P_BYPASS_EN
    assign hit1 = run_we && (AW == RA1);
    assign hit2 = run_we && (AW == RA2);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign mask1 = !in_range(RA1) || ((ZERO_REG != 0) && (RA1 == '0));
    assign mask2 = !in_range(RA2) || ((ZERO_REG != 0) && (RA2 == '0));
    assign rd1   = mask1 ? '0 : (hit1 ? Di : mem[RA1[IW-1:0]]);
    assign rd2   = mask2 ? '0 : (hit2 ? Di : mem[RA2[IW-1:0]]);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            DR1 <= '0;
            DR2 <= '0;
        end else if (state == RUN) begin
            DR1 <= rd1;
            DR2 <= rd2;
        end else begin
            DR1 <= '0;
            DR2 <= '0;
        end
    end

endmodule
